// File: rtl/cpu_step_ctrl.sv
// ============================================================================
// Module   : cpu_step_ctrl
// Brief    : CPU run/step/halt controller with PC breakpoints and retired count.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_step_ctrl #(
    parameter int CYCLES_PER_INSTR = 7,
    parameter int NUM_BP           = 2,
    parameter int PC_W             = 32,
    parameter int CNT_W            = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   run_req,
    input  logic                   step_req,
    input  logic                   halt_req,
    input  logic [NUM_BP-1:0]      bp_en,
    input  logic [NUM_BP*PC_W-1:0] bp_addr,
    input  logic [PC_W-1:0]        pc_in,
    output logic                   cpu_en,
    output logic [5:0]             phase,
    output logic                   instr_done,
    output logic                   halted,
    output logic [NUM_BP-1:0]      bp_hit,
    output logic [CNT_W-1:0]       instr_count
);

    typedef enum logic [1:0] {
        HALTED = 2'd0,
        RUN    = 2'd1,
        STEP   = 2'd2,
        BP_HIT = 2'd3
    } state_t;

    localparam logic [5:0] C_LAST_PHASE = 6'(CYCLES_PER_INSTR - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_run_prev;
    logic                r_step_prev;
    logic                r_armed;
    logic                r_bp_mask;
    logic [5:0]          r_phase;
    logic                r_instr_done;
    logic [NUM_BP-1:0]   r_bp_hit;
    logic [CNT_W-1:0]    r_instr_count;

    logic                w_run_edge;
    logic                w_step_edge;
    logic                w_cpu_en;
    logic                w_halted;
    logic                w_wrap;
    logic                w_resume;
    logic                w_bp_take;
    logic [NUM_BP-1:0]   w_match;
    logic [NUM_BP-1:0]   w_match_first;

    // r_armed suppresses a level that was already high when reset released
    assign w_run_edge  = r_armed & run_req  & ~r_run_prev;
    assign w_step_edge = r_armed & step_req & ~r_step_prev;

    assign w_cpu_en = (r_state == RUN) || (r_state == STEP);
    assign w_halted = (r_state == HALTED) || (r_state == BP_HIT);
    assign w_wrap   = w_cpu_en && (r_phase == C_LAST_PHASE);

    generate
        for (genvar k = 0; k < NUM_BP; k++) begin : g_bp
            assign w_match[k] = bp_en[k] && (bp_addr[k*PC_W +: PC_W] == pc_in);
        end
    endgenerate

    // Isolate the lowest set bit so only the lowest-index comparator is flagged
    assign w_match_first = w_match & (~w_match + NUM_BP'(1));

    // The first instruction after a resume ignores breakpoints so it can leave a bp PC
    assign w_bp_take = (r_state == RUN) && (|w_match) && !r_bp_mask;

    assign w_resume = w_halted && ((w_state_nxt == RUN) || (w_state_nxt == STEP));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            HALTED, BP_HIT: begin
                if (w_step_edge) begin
                    w_state_nxt = STEP;
                end else if (w_run_edge && !halt_req) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_wrap) begin
                    if (w_bp_take) begin
                        w_state_nxt = BP_HIT;
                    end else if (halt_req) begin
                        w_state_nxt = HALTED;
                    end
                end
            end
            STEP: begin
                if (w_wrap) begin
                    w_state_nxt = HALTED;
                end
            end
            default: w_state_nxt = HALTED;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= HALTED;
            r_run_prev    <= 1'b0;
            r_step_prev   <= 1'b0;
            r_armed       <= 1'b0;
            r_bp_mask     <= 1'b0;
            r_phase       <= 6'd0;
            r_instr_done  <= 1'b0;
            r_bp_hit      <= '0;
            r_instr_count <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_run_prev   <= run_req;
            r_step_prev  <= step_req;
            r_armed      <= 1'b1;
            r_instr_done <= w_wrap;

            if (w_wrap) begin
                r_phase       <= 6'd0;
                r_instr_count <= r_instr_count + CNT_W'(1);
            end else if (w_cpu_en) begin
                r_phase <= r_phase + 6'd1;
            end

            if (w_resume) begin
                r_bp_hit  <= '0;
                r_bp_mask <= 1'b1;
            end else if (w_wrap) begin
                r_bp_mask <= 1'b0;
                if (w_bp_take) begin
                    r_bp_hit <= w_match_first;
                end
            end
        end
    end

    assign cpu_en      = w_cpu_en;
    assign halted      = w_halted;
    assign phase       = r_phase;
    assign instr_done  = r_instr_done;
    assign bp_hit      = r_bp_hit;
    assign instr_count = r_instr_count;

endmodule

`default_nettype wire

// File: tb/tb_cpu_step_ctrl.sv
// ============================================================================
// Module   : tb_cpu_step_ctrl
// Brief    : Directed self-checking bench for cpu_step_ctrl (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_step_ctrl;

    localparam int CPI = 7;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b1;
    logic        run_req  = 1'b0;
    logic        step_req = 1'b0;
    logic        halt_req = 1'b0;
    logic [1:0]  bp_en    = 2'b00;
    logic [63:0] bp_addr  = 64'd0;
    logic [31:0] pc_in    = 32'd0;
    logic        cpu_en;
    logic [5:0]  phase;
    logic        instr_done;
    logic        halted;
    logic [1:0]  bp_hit;
    logic [31:0] instr_count;

    int n_tests = 0;
    int n_fail  = 0;
    bit pc_auto = 1'b0;

    cpu_step_ctrl #(
        .CYCLES_PER_INSTR(CPI),
        .NUM_BP(2),
        .PC_W(32),
        .CNT_W(32)
    ) u_dut (
        .clk(clk),
        .rst_n(rst_n),
        .run_req(run_req),
        .step_req(step_req),
        .halt_req(halt_req),
        .bp_en(bp_en),
        .bp_addr(bp_addr),
        .pc_in(pc_in),
        .cpu_en(cpu_en),
        .phase(phase),
        .instr_done(instr_done),
        .halted(halted),
        .bp_hit(bp_hit),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    // Behaves like a CPU presenting the next PC during the last cycle of an instruction
    always @(negedge clk) begin
        if (pc_auto && cpu_en && phase == 6'(CPI - 1)) pc_in = pc_in + 32'd4;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        run_req  = 1'b0;
        step_req = 1'b0;
        halt_req = 1'b0;
        pc_auto  = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic pulse_run();
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
    endtask

    task automatic pulse_step();
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
    endtask

    task automatic wait_halted(input string tag, input int limit);
        int n = 0;
        while (!halted && n < limit) begin
            tick();
            n++;
        end
        check(tag, halted, 1);
    endtask

    task automatic wait_phase(input string tag, input logic [5:0] p, input int limit);
        int n = 0;
        while (!(cpu_en && phase == p) && n < limit) begin
            tick();
            n++;
        end
        check(tag, phase, p);
    endtask

    task automatic wait_done(input string tag, input int limit);
        int n = 0;
        while (!instr_done && n < limit) begin
            tick();
            n++;
        end
        check(tag, instr_done, 1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        int  n;
        bit  saw_done;

        // Asynchronous reset with step_req already high
        step_req = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("rst_cpu_en", cpu_en, 0);
        check("rst_halted", halted, 1);
        check("rst_phase", phase, 0);
        check("rst_done", instr_done, 0);
        check("rst_bp_hit", bp_hit, 0);
        check("rst_count", instr_count, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        check("no_edge_after_rst", cpu_en, 0);
        step_req = 1'b0;
        tick();

        // Single step: 7 enabled cycles, second step edge inside STEP ignored
        step_req = 1'b1;
        tick();
        for (int i = 0; i < CPI; i++) begin
            check("step_cpu_en", cpu_en, 1);
            check("step_phase", phase, 6'(i));
            if (i == 1) step_req = 1'b0;
            if (i == 2) step_req = 1'b1;
            tick();
        end
        check("step_end_cpu_en", cpu_en, 0);
        check("step_end_halted", halted, 1);
        check("step_done_pulse", instr_done, 1);
        check("step_count", instr_count, 1);
        step_req = 1'b0;
        tick();
        check("step_done_once", instr_done, 0);
        check("step_stays_halted", cpu_en, 0);

        // Run into breakpoint 0 at PC 8
        do_reset();
        bp_en   = 2'b01;
        bp_addr = {32'd0, 32'd8};
        pc_in   = 32'd0;
        pc_auto = 1'b1;
        pulse_run();
        check("run_started", halted, 0);
        wait_halted("bp_wait", 40);
        check("bp_hit_idx", bp_hit, 2'b01);
        check("bp_count", instr_count, 2);
        check("bp_cpu_en", cpu_en, 0);
        check("bp_phase", phase, 0);

        // Resume at the breakpoint PC: masked, executes, then halts
        pc_auto = 1'b0;
        pulse_run();
        check("resume_bp_clr", bp_hit, 0);
        check("resume_running", halted, 0);
        halt_req = 1'b1;
        wait_halted("resume_wait", 20);
        check("resume_count", instr_count, 3);
        check("resume_bp_hit", bp_hit, 0);
        halt_req = 1'b0;
        tick();

        // halt_req mid-instruction takes effect at the boundary
        do_reset();
        bp_en = 2'b00;
        pc_in = 32'd100;
        pulse_run();
        wait_phase("halt_phase3", 6'd3, 20);
        halt_req = 1'b1;
        n = 0;
        tick();
        while (cpu_en && n < 20) begin
            n++;
            tick();
        end
        check("halt_tail_cycles", n, 3);
        check("halt_count", instr_count, 1);
        check("halt_done", instr_done, 1);
        check("halt_halted", halted, 1);

        // halt_req blocks run edges but not step edges
        run_req = 1'b1;
        tick();
        tick();
        check("run_blocked", cpu_en, 0);
        run_req = 1'b0;
        tick();
        pulse_step();
        check("step_not_blocked", cpu_en, 1);
        wait_halted("step_hold_wait", 20);
        check("step_hold_count", instr_count, 2);
        halt_req = 1'b0;
        tick();
        tick();
        check("no_late_run", cpu_en, 0);

        // Both comparators match, halt_req on the same boundary: breakpoint wins
        do_reset();
        bp_en   = 2'b11;
        bp_addr = {32'd20, 32'd20};
        pc_in   = 32'd12;
        pc_auto = 1'b1;
        pulse_run();
        wait_done("dual_first_done", 20);
        halt_req = 1'b1;
        wait_halted("dual_wait", 20);
        check("dual_bp_hit", bp_hit, 2'b01);
        check("dual_count", instr_count, 2);
        halt_req = 1'b0;

        // Only comparator 1 matches
        bp_addr = {32'd28, 32'd99};
        pulse_run();
        check("bp1_resume_clr", bp_hit, 0);
        wait_halted("bp1_wait", 40);
        check("bp1_hit", bp_hit, 2'b10);
        check("bp1_count", instr_count, 4);
        pc_auto = 1'b0;

        // Reset in the middle of a step
        pulse_step();
        check("mid_step_bp_clr", bp_hit, 0);
        check("mid_step_run", cpu_en, 1);
        wait_phase("mid_phase4", 6'd4, 20);
        check("mid_pre_count", instr_count, 4);
        #2 rst_n = 1'b0;
        #1;
        check("arst_cpu_en", cpu_en, 0);
        check("arst_halted", halted, 1);
        check("arst_phase", phase, 0);
        check("arst_done", instr_done, 0);
        check("arst_count", instr_count, 0);
        check("arst_bp_hit", bp_hit, 0);
        tick();
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (instr_done) saw_done = 1'b1;
        end
        check("arst_no_done", saw_done, 0);
        check("arst_count_hold", instr_count, 0);
        check("arst_idle", cpu_en, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
